// File: rtl/wb_traffic_pkg.sv
// wb_traffic_pkg: shared FSM/mode types and the per-beat pattern step
package wb_traffic_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_INIT, WR_BEAT, WR_GAP, RD_BEAT, RD_GAP, FINISH} state_e;
  typedef enum logic [1:0] {MODE_INC, MODE_LFSR, MODE_ADDR, MODE_WALK} mode_e;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  function automatic logic [31:0] next_pattern(input logic [31:0] p, input mode_e m);
    return (m == MODE_LFSR) ? ((p >> 1) ^ (p[0] ? LFSR_POLY : 32'h0)) : p + 32'd1;
  endfunction
endpackage

// File: rtl/wb_pattern_gen.sv
// wb_pattern_gen: 32-bit pattern state with seed load/advance and DW-wide data mux
module wb_pattern_gen import wb_traffic_pkg::*; #(
  parameter int DW = 32,
  parameter int AW = 26
) (
  input  logic                   sys_clk,
  input  logic                   RESETN,
  input  logic                   load,
  input  logic                   adv,
  input  logic [31:0]            seed,
  input  mode_e                  mode,
  input  logic [AW-1:0]          addr,
  input  logic [$clog2(DW)-1:0]  idx,
  output logic [DW-1:0]          data
);
  logic [31:0] p_q, p_d, seed_fix;
  // the first beat already carries one step past the seed
  always_comb begin
    seed_fix = (mode == MODE_LFSR && seed == 32'h0) ? 32'h1 : seed;
    p_d = load ? next_pattern(seed_fix, mode) : adv ? next_pattern(p_q, mode) : p_q;
    data = (mode == MODE_ADDR) ? DW'(addr) :
           (mode == MODE_WALK) ? DW'(1) << idx :
           (DW == 64) ? DW'({p_q, ~p_q}) : DW'(p_q);
  end
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) p_q <= '0;
    else p_q <= p_d;
  end
endmodule

// File: rtl/wb_traffic_gen.sv
// wb_traffic_gen: Wishbone master that writes a pattern, reads it back and compares
module wb_traffic_gen import wb_traffic_pkg::*; #(
  parameter int DW        = 32,
  parameter int AW        = 26,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 1024,
  parameter int ERR_W     = 16
) (
  input  logic                         sys_clk,
  input  logic                         RESETN,
  input  logic                         sdr_init_done,
  input  logic                         start,
  input  logic [AW-1:0]                cfg_base_addr,
  input  logic [15:0]                  cfg_num_bursts,
  input  logic [$clog2(MAX_BURST):0]   cfg_burst_len,
  input  logic [1:0]                   cfg_mode,
  input  logic [31:0]                  cfg_seed,
  output logic                         wb_cyc_o,
  output logic                         wb_stb_o,
  output logic                         wb_we_o,
  output logic [AW-1:0]                wb_addr_o,
  output logic [DW-1:0]                wb_dat_o,
  output logic [DW/8-1:0]              wb_sel_o,
  input  logic                         wb_ack_i,
  input  logic [DW-1:0]                wb_dat_i,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout,
  output logic [ERR_W-1:0]             err_count,
  output logic [AW-1:0]                first_err_addr,
  output logic [DW-1:0]                first_err_exp,
  output logic [DW-1:0]                first_err_got
);
  localparam int LW = $clog2(MAX_BURST) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(DW);
  localparam logic [AW-1:0] BYTES = AW'(DW / 8);
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic [AW-1:0] base_q, base_d, addr_q, addr_d, fe_addr_q, fe_addr_d;
  logic [15:0] nb_q, nb_d, burst_q, burst_d;
  logic [LW-1:0] len_q, len_d, beat_q, beat_d, len_eff;
  logic [31:0] seed_q, seed_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] wd_q, wd_d;
  logic cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [DW-1:0] fe_exp_q, fe_exp_d, fe_got_q, fe_got_d, pat;
  logic ack_beat, last_beat, last_burst, wd_hit, mismatch, pat_load, pat_adv;
  always_comb begin
    state_d = state_q; mode_d = mode_q; base_d = base_q; addr_d = addr_q;
    nb_d = nb_q; burst_d = burst_q; len_d = len_q; beat_d = beat_q;
    seed_d = seed_q; idx_d = idx_q; cyc_d = cyc_q; stb_d = stb_q; we_d = we_q;
    busy_d = busy_q; done_d = done_q; pass_d = pass_q; tmo_d = tmo_q; err_d = err_q;
    fe_addr_d = fe_addr_q; fe_exp_d = fe_exp_q; fe_got_d = fe_got_q;
    len_eff = (cfg_burst_len == '0) ? LW'(1) :
              (cfg_burst_len > LW'(MAX_BURST)) ? LW'(MAX_BURST) : cfg_burst_len;
    ack_beat = stb_q && wb_ack_i;
    last_beat = beat_q == len_q - LW'(1);
    last_burst = burst_q == nb_q - 16'd1;
    wd_d = (stb_q && !wb_ack_i) ? wd_q + TW'(1) : '0;
    wd_hit = stb_q && !wb_ack_i && wd_q == TW'(TIMEOUT - 1);
    mismatch = state_q == RD_BEAT && ack_beat && wb_dat_i != pat;
    pat_load = 1'b0;
    pat_adv = ack_beat;
    if (mismatch) begin
      err_d = &err_q ? err_q : err_q + ERR_W'(1);
      if (err_q == '0) begin
        fe_addr_d = addr_q; fe_exp_d = pat; fe_got_d = wb_dat_i;
      end
    end
    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (start) begin
          state_d = WAIT_INIT; busy_d = 1'b1; done_d = 1'b0; pass_d = 1'b0; tmo_d = 1'b0;
          err_d = '0; fe_addr_d = '0; fe_exp_d = '0; fe_got_d = '0;
          base_d = cfg_base_addr & ~(BYTES - AW'(1)); nb_d = cfg_num_bursts;
          len_d = len_eff; mode_d = mode_e'(cfg_mode); seed_d = cfg_seed;
        end
      end
      WAIT_INIT: begin
        if (nb_q == 16'd0) begin
          state_d = FINISH; busy_d = 1'b0; done_d = 1'b1; pass_d = 1'b1;
        end else if (sdr_init_done) begin
          state_d = WR_BEAT; cyc_d = 1'b1; stb_d = 1'b1; we_d = 1'b1;
          addr_d = base_q; idx_d = '0; burst_d = '0; beat_d = '0; pat_load = 1'b1;
        end
      end
      WR_BEAT, RD_BEAT: begin
        if (wd_hit) begin
          state_d = IDLE; cyc_d = 1'b0; stb_d = 1'b0; we_d = 1'b0;
          busy_d = 1'b0; done_d = 1'b1; pass_d = 1'b0; tmo_d = 1'b1;
        end else if (ack_beat) begin
          addr_d = addr_q + BYTES; idx_d = idx_q + IW'(1); beat_d = beat_q + LW'(1);
          if (last_beat) begin
            cyc_d = 1'b0; stb_d = 1'b0; beat_d = '0; burst_d = burst_q + 16'd1;
            state_d = (state_q == WR_BEAT) ? WR_GAP : last_burst ? FINISH : RD_GAP;
            if (state_q == RD_BEAT && last_burst) begin
              busy_d = 1'b0; done_d = 1'b1; pass_d = err_d == '0 && !tmo_q;
            end
          end
        end
      end
      WR_GAP: begin
        state_d = WR_BEAT; cyc_d = 1'b1; stb_d = 1'b1;
        // the gap after the final write burst doubles as the write-to-read turnaround
        if (burst_q == nb_q) begin
          state_d = RD_BEAT; we_d = 1'b0; addr_d = base_q; idx_d = '0;
          burst_d = '0; pat_load = 1'b1;
        end
      end
      RD_GAP: begin
        state_d = RD_BEAT; cyc_d = 1'b1; stb_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE; mode_q <= MODE_INC; base_q <= '0; addr_q <= '0;
      nb_q <= '0; burst_q <= '0; len_q <= '0; beat_q <= '0; seed_q <= '0;
      idx_q <= '0; wd_q <= '0; cyc_q <= 1'b0; stb_q <= 1'b0; we_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; pass_q <= 1'b0; tmo_q <= 1'b0; err_q <= '0;
      fe_addr_q <= '0; fe_exp_q <= '0; fe_got_q <= '0;
    end else begin
      state_q <= state_d; mode_q <= mode_d; base_q <= base_d; addr_q <= addr_d;
      nb_q <= nb_d; burst_q <= burst_d; len_q <= len_d; beat_q <= beat_d; seed_q <= seed_d;
      idx_q <= idx_d; wd_q <= wd_d; cyc_q <= cyc_d; stb_q <= stb_d; we_q <= we_d;
      busy_q <= busy_d; done_q <= done_d; pass_q <= pass_d; tmo_q <= tmo_d; err_q <= err_d;
      fe_addr_q <= fe_addr_d; fe_exp_q <= fe_exp_d; fe_got_q <= fe_got_d;
    end
  end
  wb_pattern_gen #(.DW(DW), .AW(AW)) u_pat (
    .sys_clk(sys_clk), .RESETN(RESETN), .load(pat_load), .adv(pat_adv),
    .seed(seed_q), .mode(mode_q), .addr(addr_q), .idx(idx_q), .data(pat)
  );
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o = we_q;
  assign wb_addr_o = addr_q;
  assign wb_dat_o = we_q ? pat : '0;
  assign wb_sel_o = {(DW/8){cyc_q}};
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign timeout = tmo_q;
  assign err_count = err_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_exp = fe_exp_q;
  assign first_err_got = fe_got_q;
endmodule

// File: doc/wb_traffic_gen.md
# wb_traffic_gen

Parametrised Wishbone master that writes a configurable pattern to SDRAM through the `sdrc_top` Wishbone port, reads it back, and compares. It sits beside `sdrc_top` on the emulation side and replaces hand-driven `wbi` stimulus. It adds four data-pattern modes, variable burst length, a bus watchdog and first-error capture.

## Interface
- `DW`, 32: Wishbone data width; one of 8/16/32/64.
- `AW`, 26: byte address width.
- `MAX_BURST`, 8: largest `cfg_burst_len` supported; a power of 2.
- `TIMEOUT`, 1024: cycles to wait for `wb_ack_i` before aborting.
- `ERR_W`, 16: width of the error counter.
- `sys_clk` in 1: clock; the same clock as `wb_clk_i` of `sdrc_top`.
- `RESETN` in 1: reset, asynchronous, active-low.
- `sdr_init_done` in 1: SDRAM initialisation complete.
- `start` in 1: one-cycle pulse that starts a run. It is ignored while `busy` is high.
- `cfg_base_addr` in AW: start byte address. Bits below `log2(DW/8)` are ignored.
- `cfg_num_bursts` in 16: number of bursts; 0 gives an immediate pass.
- `cfg_burst_len` in `$clog2(MAX_BURST)+1`: beats per burst. A value of 0 is treated as 1; values above `MAX_BURST` are clamped to `MAX_BURST`.
- `cfg_mode` in 2: 0 incrementing, 1 LFSR, 2 address-as-data, 3 walking-ones.
- `cfg_seed` in 32: pattern seed.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: Wishbone classic control.
- `wb_addr_o` out AW, `wb_dat_o` out DW, `wb_sel_o` out DW/8: Wishbone request.
- `wb_ack_i` in 1, `wb_dat_i` in DW: Wishbone response.
- `busy`, `done`, `pass`, `timeout` out 1: status.
- `err_count` out ERR_W: number of mismatching read beats; saturates at all-ones.
- `first_err_addr` out AW, `first_err_exp` out DW, `first_err_got` out DW: capture of the first mismatch.

## Operation
- States:
  - `IDLE`
  - `WAIT_INIT`
  - `WR_BEAT`
  - `WR_GAP`
  - `RD_BEAT`
  - `RD_GAP`
  - `FINISH`
- Transitions:
  - `IDLE` to `WAIT_INIT` on `start`.
  - `WAIT_INIT` to `WR_BEAT` once `sdr_init_done` is high.
  - `WAIT_INIT` to `FINISH` with `pass=1` if `cfg_num_bursts==0`.
- Config is latched on `start`. Later changes have no effect until the next run.
- Beat address: `base + (burst*len + beat)*(DW/8)`, computed modulo 2^AW. Wrap-around is legal and silent.
- Write phase:
  - All bursts are written first.
  - `wb_sel_o` is all-ones and `wb_we_o=1`.
- Read phase:
  - Starts at the same base and regenerates the pattern from `cfg_seed`.
  - On each acked read beat, `wb_dat_i` is compared with the expected data.
- Pattern generator: 32-bit state `p` that advances once per beat, reloaded with the seed at the start of each phase.
  - Mode 0: `p+1`.
  - Mode 1: Galois LFSR, polynomial 0x80200003. Seed 0 is replaced by 1.
  - Mode 2: data is the beat address, zero-extended or truncated.
  - Mode 3: data is `1 << (beat_index mod DW)`.
  - For DW=64, the data is `{p, ~p}`. For DW<32, the data is `p[DW-1:0]`.
- Mismatch handling:
  - `err_count` increments, saturating.
  - On the first mismatch only, `first_err_*` are loaded.
- Completion: after the last read beat, go to `FINISH`.
  - Set `done=1`.
  - Set `pass = (err_count==0) && !timeout`.
  - Go to `IDLE` in the next cycle.
  - `done`, `pass` and the status registers hold until the next `start`, which clears them.
- Watchdog: a counter runs while `wb_stb_o && !wb_ack_i`. When it reaches `TIMEOUT`:
  - Deassert `wb_cyc_o`/`wb_stb_o`.
  - Set `timeout=1`, `pass=0` and `done=1`.
  - Go to `IDLE`.

## Timing
- Reset values:
  - All Wishbone outputs are 0.
  - `busy`, `done`, `pass` and `timeout` are 0.
  - `err_count` and `first_err_*` are 0.
  - State is `IDLE`.
- `busy` rises on the cycle after `start` and falls on the cycle `done` rises.
- Burst:
  - `wb_cyc_o`/`wb_stb_o` are high for the whole burst.
  - Address and data advance on the edge where `wb_ack_i` is sampled high, so zero-wait-state back-to-back beats are allowed.
  - After the last beat, `cyc` and `stb` drop for exactly one cycle (`*_GAP`) before the next burst.
- Write-to-read: a single gap cycle separates the two phases.
- A read compare uses `wb_dat_i` sampled in the ack cycle. The error outputs update one cycle later.
- `start` while `busy` is high: ignored.
- `RESETN` low mid-burst: outputs clear immediately and asynchronously. The run is lost.
- `sdr_init_done` falling mid-run: ignored.

## Structure
- Package `wb_traffic_pkg` holds:
  - The state enum.
  - The `cfg_mode` enum.
  - `LFSR_POLY`.
  - A `next_pattern` function.
- Sub-module `wb_pattern_gen`: seed load, advance and mode mux, with data width `DW`. It is instantiated once and reloaded for each phase.

## Test plan
- Mode 0, base 0x100, 4 bursts × 4 beats, with a zero-wait-state slave model: 16 writes followed by 16 reads.
  - Addresses are 0x100–0x13C.
  - Data is seed+1 onward.
  - Expect `pass=1`, `err_count=0`, and `done` after 16+16+8 cycles.
- Mode 1, seed 0: the LFSR starts from state 1, and the read data matches the write data. Expect `pass=1`.
- Slave corrupts bit 3 of the read at 0x108:
  - `err_count=1`.
  - `first_err_addr=0x108`.
  - `first_err_got = exp ^ 8`.
  - `pass=0`.
- Slave never acks:
  - After `TIMEOUT` cycles, `timeout=1`, `done=1`, `pass=0`.
  - `cyc` is low on the following cycle.
- Base 0x3FFFFF8 (AW=26), 1 burst × 4 beats: the addresses wrap to 0x0 and 0x4. Expect `pass=1`.
- `RESETN` asserted in the middle of the second write burst:
  - `cyc`, `stb` and `busy` are 0 asynchronously.
  - A fresh `start` reruns the test and passes.
